// File: rtl/note_sequencer.sv
// Demo song player: walks an 8-entry song ROM and drives the one-hot note_sel bus of the tone stage.
// All outputs registered; a note is valid the cycle after a start edge; no backpressure, stop aborts on the next edge.
module note_sequencer #(
  parameter int unsigned QUARTER_NOTE = 25_000_000,
  parameter int unsigned GAP_CYCLES   = 2_500_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  output logic [7:0] note_sel,
  output logic       busy,
  output logic [2:0] step_idx,
  output logic       song_done
);

  localparam logic [31:0] QN = 32'(QUARTER_NOTE);
  localparam logic [31:0] GP = 32'(GAP_CYCLES);

  // Entry layout {dur[1:0], rest, code[2:0]}; an entry lasts (dur+1) quarter notes.
  localparam logic [5:0] SONG [8] = '{
    {2'd0, 1'b0, 3'd6},  // E-low
    {2'd0, 1'b0, 3'd5},  // A
    {2'd0, 1'b0, 3'd4},  // D
    {2'd0, 1'b0, 3'd3},  // G
    {2'd0, 1'b0, 3'd2},  // B
    {2'd1, 1'b0, 3'd1},  // E-high
    {2'd0, 1'b1, 3'd0},  // rest
    {2'd3, 1'b0, 3'd0}   // A-high
  };

  typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] cnt;
  logic        start_q;
  logic        start_edge;
  logic [2:0]  idx_nxt;
  logic        done_nxt;
  logic [7:0]  note_nxt;
  logic        busy_nxt;
  logic [1:0]  cur_dur;
  logic [31:0] note_len;
  logic        nxt_rest;
  logic [2:0]  nxt_code;

  assign start_edge = start & ~start_q;
  assign cur_dur    = SONG[step_idx][5:4];
  // Sounding part of the entry; the gap is carved out of the entry's own period.
  assign note_len   = ({30'd0, cur_dur} + 32'd1) * QN - GP;
  assign nxt_rest   = SONG[idx_nxt][3];
  assign nxt_code   = SONG[idx_nxt][2:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      cnt       <= '0;
      start_q   <= 1'b0;
      step_idx  <= 3'd0;
      note_sel  <= 8'h00;
      busy      <= 1'b0;
      song_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      start_q   <= start;
      step_idx  <= idx_nxt;
      note_sel  <= note_nxt;
      busy      <= busy_nxt;
      song_done <= done_nxt;
      if (state_nxt != state || state == S_IDLE)
        cnt <= '0;
      else
        cnt <= cnt + 32'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = step_idx;
    done_nxt  = 1'b0;
    if (stop) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            state_nxt = S_NOTE;
            idx_nxt   = 3'd0;
          end
        end
        S_NOTE: begin
          if (cnt == note_len - 32'd1)
            state_nxt = S_GAP;
        end
        S_GAP: begin
          if (cnt == GP - 32'd1) begin
            if (step_idx != 3'd7) begin
              state_nxt = S_NOTE;
              idx_nxt   = step_idx + 3'd1;
            end else if (loop_en) begin
              state_nxt = S_NOTE;
              idx_nxt   = 3'd0;
            end else begin
              state_nxt = S_IDLE;
              done_nxt  = 1'b1;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are computed from the next state so the registered values line up with it.
  always_comb begin
    note_nxt = 8'h00;
    busy_nxt = (state_nxt != S_IDLE);
    if (state_nxt == S_NOTE && !nxt_rest)
      note_nxt = 8'd1 << nxt_code;
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: scenario tasks plus a randomized run against a time-position song model.
module tb_note_sequencer;

  localparam int QN = 10;
  localparam int GP = 2;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop_en = 1'b0;
  logic [7:0] note_sel;
  logic       busy;
  logic [2:0] step_idx;
  logic       song_done;

  int n_checks = 0;
  int n_pass   = 0;

  note_sequencer #(.QUARTER_NOTE(QN), .GAP_CYCLES(GP)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .stop(stop), .loop_en(loop_en),
    .note_sel(note_sel), .busy(busy), .step_idx(step_idx), .song_done(song_done)
  );

  always #5 CLK = ~CLK;

  // Song as the player should hear it: tone code, length in quarters, rest flag.
  int rom_code [8] = '{6, 5, 4, 3, 2, 1, 0, 0};
  int rom_q    [8] = '{1, 1, 1, 1, 1, 2, 1, 4};
  bit rom_rest [8] = '{0, 0, 0, 0, 0, 0, 1, 0};

  bit m_playing, m_done, m_prev;
  int m_idx, m_pos;

  function automatic void model_reset();
    m_playing = 0; m_done = 0; m_prev = 0; m_idx = 0; m_pos = 0;
  endfunction

  function automatic void model_step();
    bit edge_seen;
    if (!RST_N) begin
      model_reset();
      return;
    end
    edge_seen = start && !m_prev;
    m_prev = start;
    m_done = 0;
    if (stop) begin
      m_playing = 0;
    end else if (!m_playing) begin
      if (edge_seen) begin
        m_playing = 1; m_idx = 0; m_pos = 0;
      end
    end else begin
      m_pos++;
      if (m_pos == rom_q[m_idx] * QN) begin
        m_pos = 0;
        if (m_idx < 7) m_idx++;
        else if (loop_en) m_idx = 0;
        else begin
          m_playing = 0; m_done = 1;
        end
      end
    end
  endfunction

  function automatic logic [7:0] m_note();
    if (m_playing && !rom_rest[m_idx] && m_pos < rom_q[m_idx] * QN - GP)
      return 8'(1 << rom_code[m_idx]);
    return 8'h00;
  endfunction

  function automatic logic [12:0] m_out();
    return {m_note(), m_playing, 3'(m_idx), m_done};
  endfunction

  function automatic logic [12:0] dut_out();
    return {note_sel, busy, step_idx, song_done};
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic go_idle();
    start = 0; stop = 1;
    tick();
    stop = 0;
    tick();
  endtask

  task automatic test_reset();
    #2 RST_N = 0;
    #2;
    model_reset();
    n_checks++;
    if (dut_out() !== 13'h0) $display("FAIL reset_state got=%h exp=%h", dut_out(), 13'h0);
    else n_pass++;
    @(negedge CLK);
    RST_N = 1;
    tick();
    n_checks++;
    if (dut_out() !== m_out()) $display("FAIL reset_idle got=%h exp=%h", dut_out(), m_out());
    else n_pass++;
  endtask

  task automatic test_first_notes();
    logic [7:0] en;
    logic [2:0] es;
    loop_en = 0;
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 20; i++) begin
      en = (i < 8) ? 8'h40 : (i < 10) ? 8'h00 : (i < 18) ? 8'h20 : 8'h00;
      es = (i < 10) ? 3'd0 : 3'd1;
      n_checks++;
      if (note_sel !== en || step_idx !== es || busy !== 1'b1)
        $display("FAIL first_notes cyc=%0d got note=%h idx=%0d busy=%b exp note=%h idx=%0d busy=1",
                 i, note_sel, step_idx, busy, en, es);
      else n_pass++;
      tick();
    end
    go_idle();
  endtask

  task automatic test_full_song();
    int c02, c01, crest, done_at, done_cnt;
    c02 = 0; c01 = 0; crest = 0; done_at = -1; done_cnt = 0;
    loop_en = 0;
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 126; i++) begin
      if (note_sel == 8'h02) c02++;
      if (note_sel == 8'h01) c01++;
      if (busy && step_idx == 3'd6 && note_sel == 8'h00) crest++;
      if (song_done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      n_checks++;
      if (dut_out() !== m_out()) $display("FAIL full_song cyc=%0d got=%h exp=%h", i, dut_out(), m_out());
      else n_pass++;
      tick();
    end
    n_checks++;
    if (c02 !== (2 * QN - GP)) $display("FAIL entry5_len got=%0d exp=%0d", c02, 2 * QN - GP);
    else n_pass++;
    n_checks++;
    if (crest !== QN) $display("FAIL entry6_rest got=%0d exp=%0d", crest, QN);
    else n_pass++;
    n_checks++;
    if (c01 !== (4 * QN - GP)) $display("FAIL entry7_len got=%0d exp=%0d", c01, 4 * QN - GP);
    else n_pass++;
    n_checks++;
    if (done_at !== 12 * QN || done_cnt !== 1)
      $display("FAIL song_done at=%0d count=%0d exp at=%0d count=1", done_at, done_cnt, 12 * QN);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || step_idx !== 3'd7) $display("FAIL song_end busy=%b idx=%0d exp busy=0 idx=7", busy, step_idx);
    else n_pass++;
  endtask

  task automatic test_loop();
    int done_cnt;
    done_cnt = 0;
    loop_en = 1;
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 130; i++) begin
      if (song_done) done_cnt++;
      if (i == 12 * QN) begin
        n_checks++;
        if (note_sel !== 8'h40 || step_idx !== 3'd0 || busy !== 1'b1)
          $display("FAIL loop_restart got note=%h idx=%0d busy=%b exp note=40 idx=0 busy=1", note_sel, step_idx, busy);
        else n_pass++;
      end
      n_checks++;
      if (dut_out() !== m_out()) $display("FAIL loop cyc=%0d got=%h exp=%h", i, dut_out(), m_out());
      else n_pass++;
      tick();
    end
    n_checks++;
    if (done_cnt !== 0) $display("FAIL loop_no_done got=%0d exp=0", done_cnt);
    else n_pass++;
    go_idle();
    loop_en = 0;
  endtask

  task automatic test_stop();
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 24; i++) tick();
    stop = 1;
    tick();
    n_checks++;
    if (note_sel !== 8'h00 || busy !== 1'b0 || step_idx !== 3'd2 || song_done !== 1'b0)
      $display("FAIL stop_abort got note=%h busy=%b idx=%0d done=%b exp note=00 busy=0 idx=2 done=0",
               note_sel, busy, step_idx, song_done);
    else n_pass++;
    stop = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (busy !== 1'b0 || step_idx !== 3'd2) $display("FAIL stop_hold busy=%b idx=%0d exp busy=0 idx=2", busy, step_idx);
      else n_pass++;
    end
    start = 1;
    tick();
    n_checks++;
    if (note_sel !== 8'h40 || step_idx !== 3'd0 || busy !== 1'b1)
      $display("FAIL stop_replay got note=%h idx=%0d busy=%b exp note=40 idx=0 busy=1", note_sel, step_idx, busy);
    else n_pass++;
    go_idle();
  endtask

  task automatic test_start_stop_together();
    start = 1; stop = 1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || note_sel !== 8'h00) $display("FAIL start_and_stop busy=%b note=%h exp busy=0 note=00", busy, note_sel);
    else n_pass++;
    stop = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (busy !== 1'b0) $display("FAIL held_start busy=%b exp=0", busy);
      else n_pass++;
    end
    start = 0;
    tick();
    start = 1;
    tick();
    n_checks++;
    if (note_sel !== 8'h40 || busy !== 1'b1) $display("FAIL retoggle_start note=%h busy=%b exp note=40 busy=1", note_sel, busy);
    else n_pass++;
    go_idle();
  endtask

  task automatic test_reset_mid();
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 33; i++) tick();
    n_checks++;
    if (note_sel !== 8'h08 || step_idx !== 3'd3) $display("FAIL entry3 note=%h idx=%0d exp note=08 idx=3", note_sel, step_idx);
    else n_pass++;
    #2 RST_N = 0;
    #1;
    model_reset();
    n_checks++;
    if (dut_out() !== 13'h0) $display("FAIL async_reset got=%h exp=%h", dut_out(), 13'h0);
    else n_pass++;
    tick();
    RST_N = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (dut_out() !== 13'h0) $display("FAIL post_reset_quiet got=%h exp=%h", dut_out(), 13'h0);
      else n_pass++;
    end
    start = 1;
    tick();
    n_checks++;
    if (note_sel !== 8'h40 || busy !== 1'b1) $display("FAIL post_reset_start note=%h busy=%b exp note=40 busy=1", note_sel, busy);
    else n_pass++;
    go_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) start = ~start;
      stop = ($urandom_range(0, 299) == 0);
      if (i % 64 == 0) loop_en = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if (dut_out() !== m_out()) $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_out(), m_out());
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_notes();
    test_full_song();
    test_loop();
    test_stop();
    test_start_stop_together();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
